// File: rtl/song_pkg.sv
// Shared definitions for the song reader: FSM state encoding and ROM word layout.
// ROM word = {note[11:6], duration[5:0]}; a duration of zero marks the end of a song.
package song_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_LOAD      = 3'd3,
    S_GUARD     = 3'd4,
    S_WAIT_NOTE = 3'd5,
    S_DONE      = 3'd6
  } song_state_t;

  localparam int ROM_W    = 12;
  localparam int NOTE_MSB = 11;
  localparam int NOTE_LSB = 6;
  localparam int DUR_MSB  = 5;
  localparam int DUR_LSB  = 0;

  localparam logic [5:0] END_DURATION = 6'd0;

  function automatic logic [ROM_W-1:0] pack_word(input logic [5:0] note, input logic [5:0] dur);
    return {note, dur};
  endfunction

endpackage

// File: rtl/song_rom.sv
// Song ROM with a one-cycle registered read. Address = {song, note_index}.
// Contents are generated per song so every slot has a defined value.
module song_rom
  import song_pkg::*;
#(
  parameter int SONG_W     = 2,
  parameter int NOTE_IDX_W = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SONG_W+NOTE_IDX_W-1:0] addr,
  output logic [ROM_W-1:0]             data
);

  localparam int ADDR_W = SONG_W + NOTE_IDX_W;

  logic [ROM_W-1:0] word_s;
  logic [ROM_W-1:0] data_r;

  // Song 0: two notes then end; song 1: 32 non-zero slots; songs 2/3: short tunes.
  function automatic logic [ROM_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [SONG_W-1:0]     s;
    logic [NOTE_IDX_W-1:0] i;
    logic [5:0]            ix6;
    logic [ROM_W-1:0]      w;
    s   = a[ADDR_W-1:NOTE_IDX_W];
    i   = a[NOTE_IDX_W-1:0];
    ix6 = 6'(i);
    w   = {ROM_W{1'b0}};
    case (s)
      SONG_W'(0): begin
        if (ix6 == 6'd0) begin
          w = pack_word(6'd10, 6'd2);
        end else if (ix6 == 6'd1) begin
          w = pack_word(6'd11, 6'd3);
        end else begin
          w = pack_word(6'd0, END_DURATION);
        end
      end
      SONG_W'(1): w = pack_word(6'd20 + ix6, 6'd4 + {4'd0, ix6[1:0]});
      SONG_W'(2): begin
        if (ix6 < 6'd5) begin
          w = pack_word(6'd40 + ix6, 6'd1);
        end else begin
          w = pack_word(6'd0, END_DURATION);
        end
      end
      SONG_W'(3): begin
        if (ix6 < 6'd8) begin
          w = pack_word(6'd1 + ix6, 6'd8);
        end else begin
          w = pack_word(6'd0, END_DURATION);
        end
      end
      default: w = pack_word(6'd0, END_DURATION);
    endcase
    return w;
  endfunction

  // Combinational lookup of the addressed word.
  always_comb begin
    word_s = rom_word(addr);
  end

  // Registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_r <= {ROM_W{1'b0}};
    end else begin
      data_r <= word_s;
    end
  end

  assign data = data_r;

endmodule

// File: rtl/song_reader.sv
// Song reader: walks the song ROM and hands note/duration pairs to the note player.
// Optional macro SONG_READER_LOOP_EN: on end marker or index wrap, restart the same song.
module song_reader
  import song_pkg::*;
#(
  parameter int SONG_W     = 2,
  parameter int NOTE_IDX_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [SONG_W-1:0] song,
  input  logic              note_done,
  output logic [5:0]        note_to_load,
  output logic [5:0]        duration_to_load,
  output logic              load_new_note,
  output logic              song_done,
  output logic              busy
);

  song_state_t           state_r, state_s;
  logic [NOTE_IDX_W-1:0] note_idx_r, note_idx_s;
  logic [SONG_W-1:0]     song_r, song_s;
  logic                  wrap_r, wrap_s;
  logic [5:0]            note_r, note_s;
  logic [5:0]            dur_r, dur_s;
  logic                  load_r, load_s;
  logic                  done_r, done_s;
  logic                  busy_r, busy_s;
  logic [ROM_W-1:0]      rom_data_s;

  song_rom #(
    .SONG_W     (SONG_W),
    .NOTE_IDX_W (NOTE_IDX_W)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .addr  ({song_r, note_idx_r}),
    .data  (rom_data_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-value logic; outputs are registered from these values.
  always_comb begin
    state_s    = state_r;
    note_idx_s = note_idx_r;
    song_s     = song_r;
    wrap_s     = wrap_r;
    note_s     = note_r;
    dur_s      = dur_r;
    load_s     = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (play) begin
          song_s     = song;
          note_idx_s = {NOTE_IDX_W{1'b0}};
          wrap_s     = 1'b0;
          state_s    = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: state_s = S_WAIT_ROM;
      S_WAIT_ROM: begin
        if (rom_data_s[DUR_MSB:DUR_LSB] == END_DURATION) begin
          done_s = 1'b1;
`ifdef SONG_READER_LOOP_EN
          note_idx_s = {NOTE_IDX_W{1'b0}};
          wrap_s     = 1'b0;
          state_s    = S_FETCH;
`else
          state_s = S_DONE;
`endif
        end else begin
          note_s  = rom_data_s[NOTE_MSB:NOTE_LSB];
          dur_s   = rom_data_s[DUR_MSB:DUR_LSB];
          load_s  = 1'b1;
          state_s = S_LOAD;
        end
      end
      S_LOAD: begin
        note_idx_s = note_idx_r + NOTE_IDX_W'(1);
        wrap_s     = (note_idx_r == {NOTE_IDX_W{1'b1}});
        state_s    = S_GUARD;
      end
      // The player's done level may still reflect the previous note here.
      S_GUARD: state_s = S_WAIT_NOTE;
      S_WAIT_NOTE: begin
        if (play && note_done) begin
          if (wrap_r) begin
            done_s = 1'b1;
            wrap_s = 1'b0;
`ifdef SONG_READER_LOOP_EN
            state_s = S_FETCH;
`else
            state_s = S_DONE;
`endif
          end else begin
            state_s = S_FETCH;
          end
        end else begin
          state_s = S_WAIT_NOTE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_idx_r <= {NOTE_IDX_W{1'b0}};
      song_r     <= {SONG_W{1'b0}};
      wrap_r     <= 1'b0;
      note_r     <= 6'd0;
      dur_r      <= 6'd0;
      load_r     <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      note_idx_r <= note_idx_s;
      song_r     <= song_s;
      wrap_r     <= wrap_s;
      note_r     <= note_s;
      dur_r      <= dur_s;
      load_r     <= load_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
    end
  end

  assign note_to_load     = note_r;
  assign duration_to_load = dur_r;
  assign load_new_note    = load_r;
  assign song_done        = done_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: stimulus queues expected events by cycle,
// a negedge monitor pops and compares them and flags any unexpected pulse.
module tb_song_reader;

  localparam int K_LOAD = 0;
  localparam int K_DONE = 1;
  localparam int K_IDLE = 2;
  localparam int K_RST  = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [5:0] note;
    logic [5:0] dur;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       play;
  logic [1:0] song;
  logic       note_done;
  logic [5:0] note_to_load;
  logic [5:0] duration_to_load;
  logic       load_new_note;
  logic       song_done;
  logic       busy;

  ev_t sb[$];
  int  cyc;
  int  checks;
  int  errors;
  bit  finished;

  song_reader #(.SONG_W(2), .NOTE_IDX_W(5)) dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .note_done        (note_done),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .song_done        (song_done),
    .busy             (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int kind, input int c, input logic [5:0] n, input logic [5:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.note = n;
    e.dur  = d;
    sb.push_back(e);
  endtask

  // Monitor: compare everything due this cycle, and every load/done pulse against expectation.
  initial begin
    ev_t e;
    int  c;
    bit  exp_load;
    bit  exp_done;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      c        = cyc;
      exp_load = 1'b0;
      exp_done = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == c) begin
          e = sb[i];
          sb.delete(i);
          case (e.kind)
            K_LOAD: begin
              exp_load = 1'b1;
              checks++;
              if (note_to_load !== e.note || duration_to_load !== e.dur) begin
                errors++;
                $display("FAIL load_data cyc=%0d got note=%0d dur=%0d exp note=%0d dur=%0d",
                         c, note_to_load, duration_to_load, e.note, e.dur);
              end
              checks++;
              if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_on_load cyc=%0d got=%b exp=1", c, busy);
              end
            end
            K_DONE: begin
              exp_done = 1'b1;
              checks++;
              if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_on_done cyc=%0d got=%b exp=1", c, busy);
              end
            end
            K_IDLE: begin
              checks++;
              if (busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_busy cyc=%0d got=%b exp=0", c, busy);
              end
            end
            default: begin
              checks++;
              if ({note_to_load, duration_to_load, load_new_note, song_done, busy} !== 15'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got note=%0d dur=%0d load=%b done=%b busy=%b exp all 0",
                         c, note_to_load, duration_to_load, load_new_note, song_done, busy);
              end
            end
          endcase
        end else if (sb[i].cyc < c) begin
          checks++;
          errors++;
          $display("FAIL stale_event cyc=%0d kind=%0d due=%0d", c, sb[i].kind, sb[i].cyc);
          sb.delete(i);
        end
      end
      if (load_new_note === 1'b1 || exp_load) begin
        checks++;
        if (load_new_note !== exp_load) begin
          errors++;
          $display("FAIL load_pulse cyc=%0d got=%b exp=%b", c, load_new_note, exp_load);
        end
      end
      if (song_done === 1'b1 || exp_done) begin
        checks++;
        if (song_done !== exp_done) begin
          errors++;
          $display("FAIL done_pulse cyc=%0d got=%b exp=%b", c, song_done, exp_done);
        end
      end
      if (finished) begin
        foreach (sb[i]) begin
          checks++;
          errors++;
          $display("FAIL unseen_event kind=%0d due=%0d", sb[i].kind, sb[i].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // Directed stimulus; expected events are queued with their absolute cycle.
  initial begin
    int k;
    int j;
    finished  = 1'b0;
    reset     = 1'b0;
    play      = 1'b0;
    song      = 2'd0;
    note_done = 1'b0;
    step(1);
    expect_ev(K_RST, cyc, 6'd0, 6'd0);
    step(1);
    reset = 1'b1;
    step(1);
    expect_ev(K_IDLE, cyc, 6'd0, 6'd0);
    step(1);

    // Song 1: all 32 slots, note_done held high, song input changed mid-song.
    song      = 2'd1;
    play      = 1'b1;
    note_done = 1'b1;
    k         = cyc;
    for (int i = 0; i < 32; i++) begin
      expect_ev(K_LOAD, k + 3 + 5 * i, 6'(20 + i), 6'(4 + (i % 4)));
    end
    expect_ev(K_DONE, k + 161, 6'd0, 6'd0);
    expect_ev(K_IDLE, k + 162, 6'd0, 6'd0);
    step(50);
    song = 2'd3;
    step(111);
    play = 1'b0;
    step(3);

    // Song 0: end marker at slot 2; play dropped during FETCH must not stall.
    song = 2'd0;
    play = 1'b1;
    k    = cyc;
    expect_ev(K_LOAD, k + 3, 6'd10, 6'd2);
    expect_ev(K_LOAD, k + 8, 6'd11, 6'd3);
    expect_ev(K_DONE, k + 13, 6'd0, 6'd0);
    expect_ev(K_IDLE, k + 14, 6'd0, 6'd0);
    step(11);
    play = 1'b0;
    step(5);

    // Song 2: pause in WAIT_NOTE with note_done high for 10 cycles.
    song      = 2'd2;
    play      = 1'b1;
    note_done = 1'b0;
    k         = cyc;
    expect_ev(K_LOAD, k + 3, 6'd40, 6'd1);
    expect_ev(K_LOAD, k + 18, 6'd41, 6'd1);
    expect_ev(K_LOAD, k + 23, 6'd42, 6'd1);
    expect_ev(K_LOAD, k + 28, 6'd43, 6'd1);
    expect_ev(K_LOAD, k + 33, 6'd44, 6'd1);
    expect_ev(K_DONE, k + 38, 6'd0, 6'd0);
    expect_ev(K_IDLE, k + 39, 6'd0, 6'd0);
    step(5);
    play      = 1'b0;
    note_done = 1'b1;
    step(10);
    play = 1'b1;
    step(21);
    play = 1'b0;
    step(5);

    // Song 3: reset mid-WAIT_NOTE, then a full replay from slot 0.
    song      = 2'd3;
    play      = 1'b1;
    note_done = 1'b0;
    k         = cyc;
    expect_ev(K_LOAD, k + 3, 6'd1, 6'd8);
    step(6);
    reset = 1'b0;
    play  = 1'b0;
    expect_ev(K_RST, cyc, 6'd0, 6'd0);
    expect_ev(K_RST, cyc + 1, 6'd0, 6'd0);
    step(2);
    reset = 1'b1;
    step(2);
    j = cyc;
    expect_ev(K_IDLE, j, 6'd0, 6'd0);
    play      = 1'b1;
    note_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_ev(K_LOAD, j + 3 + 5 * i, 6'(1 + i), 6'd8);
    end
    expect_ev(K_DONE, j + 43, 6'd0, 6'd0);
    expect_ev(K_IDLE, j + 44, 6'd0, 6'd0);
    step(41);
    play = 1'b0;
    step(6);

    finished = 1'b1;
    step(3);
    $display("FAIL monitor_stalled");
    $fatal(1);
  end

endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 SHALL have parameter SONG_W, default 2, meaning song-select width (4 songs).
REQ-002 SHALL have parameter NOTE_IDX_W, default 5, meaning note-index width (32 note slots per song).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 play  input  1  high = advance through song; low = pause.
REQ-006 song  input  SONG_W  song select, sampled only when leaving IDLE.
REQ-007 note_done  input  1  level from note player, high when current note duration has elapsed.
REQ-008 note_to_load  output  6  note code to the note player, registered.
REQ-009 duration_to_load  output  6  duration in beats to the note player, registered.
REQ-010 load_new_note  output  1  one-cycle pulse; note/duration valid in the same cycle.
REQ-011 song_done  output  1  one-cycle pulse when the song ends.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, FETCH, WAIT_ROM, LOAD, GUARD, WAIT_NOTE, DONE.
REQ-014 IDLE: when play=1, SHALL latch song, clear note index to 0, and go to FETCH.
REQ-015 FETCH: SHALL present ROM address {song_latched, note_index} and go to WAIT_ROM (ROM latency 1 cycle).
REQ-016 WAIT_ROM: SHALL capture ROM word {note[11:6], duration[5:0]}; if duration==0 (end marker) go to DONE, else go to LOAD.
REQ-017 LOAD: SHALL drive load_new_note=1 for exactly this cycle with captured note/duration, increment note_index modulo 2^NOTE_IDX_W, and go to GUARD.
REQ-018 GUARD: SHALL ignore note_done for one cycle (the player's done level from the previous note may still be high) and go to WAIT_NOTE.
REQ-019 WAIT_NOTE: when note_done=1 and play=1, SHALL go to FETCH; if play=0, SHALL hold regardless of note_done.
REQ-020 Index wrap from 2^NOTE_IDX_W-1 to 0 SHALL be treated as song end (go to DONE after that note completes) unless REQ-027 applies.
REQ-021 DONE: SHALL pulse song_done for one cycle and go to IDLE.
REQ-022 Latency: load_new_note SHALL assert exactly 3 cycles after the edge on which IDLE samples play=1; next-note load 3 cycles after note_done is sampled in WAIT_NOTE.
REQ-023 play=0 in FETCH/WAIT_ROM/LOAD/GUARD SHALL NOT stall those states; pause takes effect only in WAIT_NOTE and IDLE.
REQ-024 Changes on song while busy SHALL be ignored until the next IDLE exit.
REQ-025 note_to_load/duration_to_load SHALL hold their last loaded values until the next LOAD.

Reset
REQ-026 On reset low, asynchronously: state=IDLE, note_index=0, song latch=0, all outputs 0; reset mid-note SHALL abandon the song with no song_done pulse.

Configuration
REQ-027 Macro SONG_READER_LOOP_EN: when defined, end marker or index wrap SHALL restart at index 0 of the same song (go to FETCH, song_done still pulses one cycle); when undefined, SHALL go to DONE then IDLE.

Structure
REQ-028 Shared package song_pkg SHALL hold state encoding, ROM word layout constants (NOTE_MSB/LSB, DUR_MSB/LSB) and END_DURATION=0.
REQ-029 SHALL instantiate one sub-module song_rom (address SONG_W+NOTE_IDX_W bits, 12-bit data, 1-cycle registered read).

Verification
REQ-030 Reset low mid-WAIT_NOTE -> all outputs 0 within same cycle; after release and play=1, first load is index 0.
REQ-031 song=1, play=1 from IDLE, ROM[32]={note 6'd20,dur 6'd4} -> load_new_note at cycle 3 with note=20, duration=4, busy=1.
REQ-032 note_done held high through LOAD and GUARD -> no second load until note_done sampled in WAIT_NOTE.
REQ-033 play=0 while in WAIT_NOTE with note_done=1 for 10 cycles -> no load; play=1 -> load 3 cycles later.
REQ-034 ROM[2] duration=0 -> after 2 notes, song_done pulse one cycle, then busy=0 (LOOP_EN: load of index 0 follows).
REQ-035 All 32 slots nonzero -> 32 loads then song_done; song changed to 3 mid-song -> still song 1 data.
